// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop, LSB first,
// behind a valid/ready request port and a valid/ready result port.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             bf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             d_bit, bf_next;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign d_bit   = a_q[0] ^ b_q[0] ^ bf_q;
    assign bf_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bf_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            bf_q       <= 1'b0;
            cnt_q      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        bf_q     <= borrow_in;
                        cnt_q    <= '0;
                        state_q  <= StRun;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= {d_bit, res_q[WIDTH-1:1]};
                    bf_q  <= bf_next;
                    cnt_q <= cnt_q + 1'b1;
                    // Publish the result together with the last bit so it is stable for DONE.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q    <= StDone;
                        out_valid  <= 1'b1;
                        diff       <= {d_bit, res_q[WIDTH-1:1]};
                        borrow_out <= bf_next;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes reference results, a monitor
// pops and compares them whenever a result is presented.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;

    logic         in_valid8 = 1'b0;
    logic         in_ready8;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         borrow_in8 = 1'b0;
    logic         out_valid8;
    logic [7:0]   diff8;
    logic         borrow_out8;
    logic         busy8;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bp_mode = 0;       // 0: out_ready=1, 1: out_ready=0, 2: random
    bit tput_mode = 0;
    int prev_hs = -1;

    logic [W:0] exp_q[$];  // {borrow, diff}
    int         acc_q[$];

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
        .borrow_out(borrow_out), .busy(busy)
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .borrow_in(borrow_in8), .out_valid(out_valid8), .out_ready(1'b1), .diff(diff8),
        .borrow_out(borrow_out8), .busy(busy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer subtraction, borrow when the subtrahend exceeds the minuend.
    function automatic logic [W:0] ref_sub(input int ra, input int rb, input int rbin);
        int d;
        d = ra - rb - rbin;
        return {1'(d < 0), W'(d & ((1 << W) - 1))};
    endfunction

    task automatic accept_raw(input int ta, input int tb, input int tbin, output int acc);
        int n = 0;
        @(negedge clk);
        a = W'(ta); b = W'(tb); borrow_in = 1'(tbin); in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
    endtask

    task automatic send(input int ta, input int tb, input int tbin);
        int acc;
        accept_raw(ta, tb, tbin, acc);
        exp_q.push_back(ref_sub(ta, tb, tbin));
        acc_q.push_back(acc);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(exp_q.size() == 0 && !out_valid), 1);
    endtask

    // Monitor: first sight of out_valid checks value and latency; later DONE cycles check hold.
    bit         seen = 0;
    logic [W:0] hold;
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1;
                hold = {borrow_out, diff};
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("result", int'({borrow_out, diff}), int'(exp_q.pop_front()));
                    chk("latency", cyc - acc_q.pop_front(), W + 1);
                end
            end else begin
                chk("hold_result", int'({borrow_out, diff}), int'(hold));
                chk("hold_in_ready", int'(in_ready), 0);
            end
            if (out_ready) begin
                seen = 0;
                if (tput_mode && prev_hs >= 0) chk("throughput", cyc - prev_hs, W + 2);
                prev_hs = cyc;
            end
        end
    end

    initial begin
        int acc, n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_borrow", int'(borrow_out), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        send(9, 3, 0);
        send(3, 9, 0);
        send(0, 0, 1);
        drain();

        // Exhaustive, back-to-back with out_ready held high.
        tput_mode = 1;
        prev_hs = -1;
        for (int i = 0; i < 512; i++) send(i & 15, (i >> 4) & 15, i >> 8);
        drain();
        tput_mode = 0;

        // Backpressure: hold DONE for 7 cycles while a new request is waved at the block.
        bp_mode = 1;
        send(12, 5, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", int'(out_valid), 1);
        a = 4'd1; b = 4'd2; borrow_in = 1'b0; in_valid = 1'b1;
        repeat (7) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_busy", int'(busy), 1);
        end
        in_valid = 1'b0;
        bp_mode = 0;
        n = 0;
        while (out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_release_cycles", n, 2);
        chk("bp_idle_in_ready", int'(in_ready), 1);
        repeat (8) @(negedge clk);
        chk("bp_no_extra", int'(out_valid), 0);

        // Reset after two bit cycles of 15-1 discards the operation.
        accept_raw(15, 1, 0, acc);
        @(posedge clk);
        @(negedge clk);
        chk("run_busy", int'(busy), 1);
        chk("run_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_busy", int'(busy), 0);
        send(15, 15, 1);
        drain();

        // Random operands with random backpressure.
        bp_mode = 2;
        for (int i = 0; i < 150; i++) send($urandom_range(0, 15), $urandom_range(0, 15),
                                           $urandom_range(0, 1));
        drain();
        bp_mode = 0;

        // WIDTH=8 instance: 0 - 1 wraps to 0xFF with borrow, latency WIDTH+1.
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h01; borrow_in8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("w8_latency", n, 9);
        chk("w8_diff", int'(diff8), 255);
        chk("w8_borrow", int'(borrow_out8), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
